// File: rtl/id_ex_pipe_reg_if.sv
// Decode->Execute bundle: D-side operands/controls in, E-side registered copy out.
// slave = pipeline register, master = decode/execute environment. Counters with ID_EX_PERF_CNT_EN.
interface id_ex_pipe_reg_if #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 3,
  parameter int IMMSRC_W  = 2
);
  logic                 valid_d;
  logic                 regwrite_d;
  logic                 alusrc_d;
  logic                 memwrite_d;
  logic                 resultsrc_d;
  logic                 branch_d;
  logic [IMMSRC_W-1:0]  immsrc_d;
  logic [ALUCTRL_W-1:0] alucontrol_d;
  logic [XLEN-1:0]      rd1_d;
  logic [XLEN-1:0]      rd2_d;
  logic [XLEN-1:0]      imm_ext_d;
  logic [XLEN-1:0]      pc_d;
  logic [XLEN-1:0]      pcplus4_d;
  logic [REG_AW-1:0]    rs1_d;
  logic [REG_AW-1:0]    rs2_d;
  logic [REG_AW-1:0]    rd_d;
  logic                 flush_e;
  logic                 stall_e;

  logic                 valid_e;
  logic                 regwrite_e;
  logic                 alusrc_e;
  logic                 memwrite_e;
  logic                 resultsrc_e;
  logic                 branch_e;
  logic [IMMSRC_W-1:0]  immsrc_e;
  logic [ALUCTRL_W-1:0] alucontrol_e;
  logic [XLEN-1:0]      rd1_e;
  logic [XLEN-1:0]      rd2_e;
  logic [XLEN-1:0]      imm_ext_e;
  logic [XLEN-1:0]      pc_e;
  logic [XLEN-1:0]      pcplus4_e;
  logic [XLEN-1:0]      srcb_e;
  logic [XLEN-1:0]      writedata_e;
  logic [REG_AW-1:0]    rs1_e;
  logic [REG_AW-1:0]    rs2_e;
  logic [REG_AW-1:0]    rd_e;
  logic                 stall_d;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]          bubble_cnt;
  logic [31:0]          flush_cnt;

  modport slave (
    input  valid_d, regwrite_d, alusrc_d, memwrite_d,
           resultsrc_d, branch_d, immsrc_d, alucontrol_d,
           rd1_d, rd2_d, imm_ext_d, pc_d, pcplus4_d,
           rs1_d, rs2_d, rd_d, flush_e, stall_e,
    output valid_e, regwrite_e, alusrc_e, memwrite_e,
           resultsrc_e, branch_e, immsrc_e, alucontrol_e,
           rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e,
           srcb_e, writedata_e, rs1_e, rs2_e, rd_e,
           stall_d, bubble_cnt, flush_cnt
  );

  modport master (
    output valid_d, regwrite_d, alusrc_d, memwrite_d,
           resultsrc_d, branch_d, immsrc_d, alucontrol_d,
           rd1_d, rd2_d, imm_ext_d, pc_d, pcplus4_d,
           rs1_d, rs2_d, rd_d, flush_e, stall_e,
    input  valid_e, regwrite_e, alusrc_e, memwrite_e,
           resultsrc_e, branch_e, immsrc_e, alucontrol_e,
           rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e,
           srcb_e, writedata_e, rs1_e, rs2_e, rd_e,
           stall_d, bubble_cnt, flush_cnt
  );
`else
  modport slave (
    input  valid_d, regwrite_d, alusrc_d, memwrite_d,
           resultsrc_d, branch_d, immsrc_d, alucontrol_d,
           rd1_d, rd2_d, imm_ext_d, pc_d, pcplus4_d,
           rs1_d, rs2_d, rd_d, flush_e, stall_e,
    output valid_e, regwrite_e, alusrc_e, memwrite_e,
           resultsrc_e, branch_e, immsrc_e, alucontrol_e,
           rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e,
           srcb_e, writedata_e, rs1_e, rs2_e, rd_e,
           stall_d
  );

  modport master (
    output valid_d, regwrite_d, alusrc_d, memwrite_d,
           resultsrc_d, branch_d, immsrc_d, alucontrol_d,
           rd1_d, rd2_d, imm_ext_d, pc_d, pcplus4_d,
           rs1_d, rs2_d, rd_d, flush_e, stall_e,
    input  valid_e, regwrite_e, alusrc_e, memwrite_e,
           resultsrc_e, branch_e, immsrc_e, alucontrol_e,
           rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e,
           srcb_e, writedata_e, rs1_e, rs2_e, rd_e,
           stall_d
  );
`endif
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: flush > hold > load-use bubble > capture; stall_d is combinational.
// Ports: clk, rst (async active-low), io (slave). ID_EX_PERF_CNT_EN adds bubble/flush counters.
module id_ex_pipe_reg #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 3,
  parameter int IMMSRC_W  = 2
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_pipe_reg_if.slave io
);

  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic                 alusrc;
    logic                 memwrite;
    logic                 resultsrc;
    logic                 branch;
    logic [IMMSRC_W-1:0]  immsrc;
    logic [ALUCTRL_W-1:0] alucontrol;
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;
    logic [XLEN-1:0]      imm_ext;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pcplus4;
    logic [XLEN-1:0]      srcb;
    logic [XLEN-1:0]      wdata;
    logic [REG_AW-1:0]    rs1;
    logic [REG_AW-1:0]    rs2;
    logic [REG_AW-1:0]    rd;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t ex_d;
  id_ex_t cap;
  logic   load_use;

  // x0 is never a real producer, so rd==0 cannot hazard.
  assign load_use = ex_q.valid & ex_q.resultsrc
                  & ex_q.regwrite & (ex_q.rd != '0)
                  & io.valid_d
                  & ((ex_q.rd == io.rs1_d)
                   | (ex_q.rd == io.rs2_d));

  assign io.stall_d = rst & (load_use | io.stall_e);

  // An invalid slot keeps its fields but may not write or branch.
  always_comb begin
    cap            = '0;
    cap.valid      = io.valid_d;
    cap.regwrite   = io.valid_d & io.regwrite_d;
    cap.alusrc     = io.alusrc_d;
    cap.memwrite   = io.valid_d & io.memwrite_d;
    cap.resultsrc  = io.resultsrc_d;
    cap.branch     = io.valid_d & io.branch_d;
    cap.immsrc     = io.immsrc_d;
    cap.alucontrol = io.alucontrol_d;
    cap.rd1        = io.rd1_d;
    cap.rd2        = io.rd2_d;
    cap.imm_ext    = io.imm_ext_d;
    cap.pc         = io.pc_d;
    cap.pcplus4    = io.pcplus4_d;
    cap.srcb       = io.alusrc_d ? io.imm_ext_d
                                 : io.rd2_d;
    cap.wdata      = io.rd2_d;
    cap.rs1        = io.rs1_d;
    cap.rs2        = io.rs2_d;
    cap.rd         = io.rd_d;
  end

  always_comb begin
    ex_d = cap;
    priority case (1'b1)
      io.flush_e: ex_d = '0;
      io.stall_e: ex_d = ex_q;
      load_use:   ex_d = '0;
      default:    ex_d = cap;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ex_q <= '0;
    else      ex_q <= ex_d;
  end

  assign io.valid_e      = ex_q.valid;
  assign io.regwrite_e   = ex_q.regwrite;
  assign io.alusrc_e     = ex_q.alusrc;
  assign io.memwrite_e   = ex_q.memwrite;
  assign io.resultsrc_e  = ex_q.resultsrc;
  assign io.branch_e     = ex_q.branch;
  assign io.immsrc_e     = ex_q.immsrc;
  assign io.alucontrol_e = ex_q.alucontrol;
  assign io.rd1_e        = ex_q.rd1;
  assign io.rd2_e        = ex_q.rd2;
  assign io.imm_ext_e    = ex_q.imm_ext;
  assign io.pc_e         = ex_q.pc;
  assign io.pcplus4_e    = ex_q.pcplus4;
  assign io.srcb_e       = ex_q.srcb;
  assign io.writedata_e  = ex_q.wdata;
  assign io.rs1_e        = ex_q.rs1;
  assign io.rs2_e        = ex_q.rs2;
  assign io.rd_e         = ex_q.rd;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        bub_ins;

  // Only a load-use bubble counts; flush and hold take precedence.
  assign bub_ins = ~io.flush_e & ~io.stall_e & load_use;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (bub_ins && bubble_cnt_q != '1)
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (io.flush_e && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign io.bubble_cnt = bubble_cnt_q;
  assign io.flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed steps then random traffic
// checked against a cycle-level reference model of the spec rules.
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_pipe_reg_if bus ();
  id_ex_pipe_reg dut (.clk(clk), .rst(rst), .io(bus));

  typedef struct packed {
    logic        valid, rw, alusrc, mw, res, br;
    logic [1:0]  immsrc;
    logic [2:0]  aluc;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } din_t;

  typedef struct packed {
    logic        valid, rw, alusrc, mw, res, br;
    logic [1:0]  immsrc;
    logic [2:0]  aluc;
    logic [31:0] rd1, rd2, imm, pc, pc4, srcb, wd;
    logic [4:0]  rs1, rs2, rd;
  } ex_m_t;

  din_t  din;
  ex_m_t m;
  logic  flush, stall;
  int    checks = 0;
  int    failures = 0;
  logic [255:0] snap;
  longint bub_m = 0, fl_m = 0;

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic din_t rnd_din();
    din_t d;
    d.valid  = ($urandom_range(0, 9) < 8);
    d.rw     = 1'($urandom);
    d.alusrc = 1'($urandom);
    d.mw     = 1'($urandom);
    d.res    = 1'($urandom);
    d.br     = 1'($urandom);
    d.immsrc = 2'($urandom);
    d.aluc   = 3'($urandom);
    d.rd1    = $urandom;
    d.rd2    = $urandom;
    d.imm    = $urandom;
    d.pc     = $urandom;
    d.pc4    = $urandom;
    d.rs1    = 5'($urandom_range(0, 3));
    d.rs2    = 5'($urandom_range(0, 3));
    d.rd     = 5'($urandom_range(0, 3));
    return d;
  endfunction

  task automatic drive();
    bus.valid_d      = din.valid;
    bus.regwrite_d   = din.rw;
    bus.alusrc_d     = din.alusrc;
    bus.memwrite_d   = din.mw;
    bus.resultsrc_d  = din.res;
    bus.branch_d     = din.br;
    bus.immsrc_d     = din.immsrc;
    bus.alucontrol_d = din.aluc;
    bus.rd1_d        = din.rd1;
    bus.rd2_d        = din.rd2;
    bus.imm_ext_d    = din.imm;
    bus.pc_d         = din.pc;
    bus.pcplus4_d    = din.pc4;
    bus.rs1_d        = din.rs1;
    bus.rs2_d        = din.rs2;
    bus.rd_d         = din.rd;
    bus.flush_e      = flush;
    bus.stall_e      = stall;
  endtask

  function automatic logic [255:0] obs_e();
    return 256'({bus.valid_e, bus.regwrite_e, bus.alusrc_e,
      bus.memwrite_e, bus.resultsrc_e, bus.branch_e,
      bus.immsrc_e, bus.alucontrol_e, bus.rd1_e, bus.rd2_e,
      bus.imm_ext_e, bus.pc_e, bus.pcplus4_e, bus.srcb_e,
      bus.writedata_e, bus.rs1_e, bus.rs2_e, bus.rd_e});
  endfunction

  function automatic logic [255:0] exp_e();
    return 256'(m);
  endfunction

  // Hazard: the instruction in E is a load whose target D reads.
  function automatic logic hazard();
    return m.valid && m.res && m.rw && m.rd != 0 && din.valid
        && (m.rd == din.rs1 || m.rd == din.rs2);
  endfunction

  task automatic model_edge();
    ex_m_t n;
    if (flush) begin
      m = '0;
      fl_m = (fl_m < 64'hFFFFFFFF) ? fl_m + 1 : fl_m;
    end else if (stall) begin
      m = m;
    end else if (hazard()) begin
      m = '0;
      bub_m = (bub_m < 64'hFFFFFFFF) ? bub_m + 1 : bub_m;
    end else begin
      n.valid  = din.valid;
      n.rw     = din.valid ? din.rw : 1'b0;
      n.mw     = din.valid ? din.mw : 1'b0;
      n.br     = din.valid ? din.br : 1'b0;
      n.alusrc = din.alusrc;
      n.res    = din.res;
      n.immsrc = din.immsrc;
      n.aluc   = din.aluc;
      n.rd1    = din.rd1;
      n.rd2    = din.rd2;
      n.imm    = din.imm;
      n.pc     = din.pc;
      n.pc4    = din.pc4;
      n.srcb   = din.alusrc ? din.imm : din.rd2;
      n.wd     = din.rd2;
      n.rs1    = din.rs1;
      n.rs2    = din.rs2;
      n.rd     = din.rd;
      m = n;
    end
  endtask

  task automatic step(string tag);
    drive();
    #1;
    chk({tag, "_stall_d"}, 256'(bus.stall_d),
        256'(hazard() | stall));
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_e"}, obs_e(), exp_e());
`ifdef ID_EX_PERF_CNT_EN
    chk({tag, "_cnt"}, 256'({bus.bubble_cnt, bus.flush_cnt}),
        256'({bub_m[31:0], fl_m[31:0]}));
`endif
  endtask

  task automatic async_reset(string tag);
    #3;
    rst = 1'b0;
    #1;
    m = '0;
    bub_m = 0;
    fl_m = 0;
    chk({tag, "_e"}, obs_e(), 256'(0));
    chk({tag, "_stall_d"}, 256'(bus.stall_d), 256'(0));
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    din = rnd_din();
    din.valid = 1'b1;
    m = '0;
    drive();
    #12;
    chk("reset_init", obs_e(), 256'(0));
    rst = 1'b1;

    // Fill E with nonzero content, then reset mid-cycle with stall_e high.
    din = rnd_din();
    din.valid = 1'b1;
    din.rd1 = 32'hDEAD_BEEF;
    step("fill");
    stall = 1'b1;
    drive();
    async_reset("reset_mid");
    stall = 1'b0;

    din = '0;
    din.valid = 1'b1;
    din.rd1 = 32'h11;
    din.rd2 = 32'h22;
    din.imm = 32'h33;
    din.alusrc = 1'b1;
    din.rd = 5'd5;
    step("cap_imm");
    chk("cap_srcb", 256'(bus.srcb_e), 256'(32'h33));
    chk("cap_wdata", 256'(bus.writedata_e), 256'(32'h22));
    chk("cap_rd", 256'(bus.rd_e), 256'(5));
    din.alusrc = 1'b0;
    step("cap_reg");
    chk("cap_srcb_reg", 256'(bus.srcb_e), 256'(32'h22));

    // Load-use on rs2.
    din = rnd_din();
    din.valid = 1'b1;
    din.res = 1'b1;
    din.rw = 1'b1;
    din.rd = 5'd7;
    din.rs1 = 5'd1;
    din.rs2 = 5'd2;
    step("ld");
    din = rnd_din();
    din.valid = 1'b1;
    din.rs1 = 5'd3;
    din.rs2 = 5'd7;
    drive();
    #1;
    chk("lu_stall_d", 256'(bus.stall_d), 256'(1));
    step("lu_bubble");
    chk("lu_bubble_valid", 256'(bus.valid_e), 256'(0));
    step("lu_capture");
    chk("lu_capture_rs2", 256'(bus.rs2_e), 256'(7));

    // Load targeting x0 never stalls.
    din.res = 1'b1;
    din.rw = 1'b1;
    din.rd = 5'd0;
    step("ld_x0");
    din.rs1 = 5'd0;
    din.rs2 = 5'd0;
    step("x0_nohaz");
    chk("x0_valid", 256'(bus.valid_e), 256'(1));

    // Hold for three cycles while D changes.
    snap = obs_e();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = rnd_din();
      step("hold");
      chk("hold_snap", obs_e(), snap);
    end
    stall = 1'b0;
    step("hold_release");

    // Flush beats stall.
    din = rnd_din();
    din.valid = 1'b1;
    din.mw = 1'b1;
    step("st");
    flush = 1'b1;
    stall = 1'b1;
    step("flush_stall");
    chk("flush_valid", 256'(bus.valid_e), 256'(0));
    chk("flush_mw", 256'(bus.memwrite_e), 256'(0));
    flush = 1'b0;
    stall = 1'b0;

    din = rnd_din();
    din.valid = 1'b0;
    din.mw = 1'b1;
    din.rw = 1'b1;
    din.br = 1'b1;
    step("invalid");
    chk("invalid_ctl",
        256'({bus.valid_e, bus.memwrite_e, bus.regwrite_e}),
        256'(0));

    // Reset while a hazard is pending.
    din = rnd_din();
    din.valid = 1'b1;
    din.res = 1'b1;
    din.rw = 1'b1;
    din.rd = 5'd2;
    step("ld2");
    din = rnd_din();
    din.valid = 1'b1;
    din.rs1 = 5'd2;
    drive();
    async_reset("reset_haz");
    step("after_reset");

    for (int i = 0; i < 300; i++) begin
      din = rnd_din();
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised Decode→Execute pipeline register for the RISC-V pipeline. Successor to the fixed-width decode-stage register.
- Adds a valid bit, downstream stall/hold, branch flush and load-use hazard detection with bubble insertion.
- Forms the ALU operand-B select and the store write-data in the register stage.
- Sits between the decode logic (control unit, register file, sign extend) and the execute stage.

Parameters:
- XLEN, 32, data/address width of the register operands, immediate and PC.
- REG_AW, 5, register-index width.
- ALUCTRL_W, 3, ALUControl width.
- IMMSRC_W, 2, ImmSrc width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_d  in  1  decode slot holds a real instruction.
- regwrite_d, alusrc_d, memwrite_d, resultsrc_d, branch_d  in  1 each  decoded control bits.
- immsrc_d  in  IMMSRC_W  immediate format.
- alucontrol_d  in  ALUCTRL_W  ALU operation.
- rd1_d, rd2_d, imm_ext_d, pc_d, pcplus4_d  in  XLEN each  decode-stage operands.
- rs1_d, rs2_d, rd_d  in  REG_AW each  register indices.
- flush_e  in  1  squash the E slot (taken branch).
- stall_e  in  1  execute-side hold request.
- valid_e, regwrite_e, alusrc_e, memwrite_e, resultsrc_e, branch_e  out  1 each  registered controls.
- immsrc_e  out  IMMSRC_W.
- alucontrol_e  out  ALUCTRL_W.
- rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e, srcb_e, writedata_e  out  XLEN each.
- rs1_e, rs2_e, rd_e  out  REG_AW each.
- stall_d  out  1  hold fetch/decode (combinational).

Behaviour:
- Reset: rst low asynchronously clears every registered output to 0 (valid_e=0, all controls 0, all data/index fields 0). stall_d=0 while in reset. Release is synchronous to the next clk edge.
- Load-use hazard (combinational): load_use = valid_e & resultsrc_e & regwrite_e & (rd_e!=0) & valid_d & ((rd_e==rs1_d) | (rd_e==rs2_d)).
- stall_d = load_use | stall_e.
- Per-edge update, priority highest first:
  1. flush_e=1: load a bubble.
  2. stall_e=1: hold all registers.
  3. load_use=1: load a bubble.
  4. Otherwise capture the D inputs.
- Bubble means valid_e=0 and every control, data and index field set to 0.
- Capture:
  - All _e fields take the matching _d values. valid_e=valid_d.
  - srcb_e = alusrc_d ? imm_ext_d : rd2_d.
  - writedata_e = rd2_d.
- valid_d=0 while capturing: fields are captured as-is, but regwrite_e, memwrite_e and branch_e are forced to 0, so an invalid slot never writes or branches.
- Latency: exactly one cycle from D inputs to _e outputs. No combinational path from D inputs to _e outputs. stall_d is the only combinational output.
- Simultaneous flush_e and stall_e: flush wins and the slot becomes a bubble. stall_d stays asserted while stall_e=1.
- Back-to-back load-use: after the bubble, valid_e=0, so load_use deasserts and the held D instruction is captured next cycle. Each hazard costs exactly one bubble.
- rd_e==0 never creates a hazard (x0).
- Reset mid-stall or mid-hazard: all state clears immediately. No pending bubble survives reset.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs bubble_cnt (32) and flush_cnt (32).
  - bubble_cnt increments on every load-use bubble insertion. flush_cnt increments on every edge with flush_e=1.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
  - A hold edge (stall_e=1 without flush) increments neither counter.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Test Plan:
- Reset: drive all D inputs nonzero, pulse rst=0 mid-cycle → all _e outputs 0 immediately, with no clk edge needed.
- Capture: valid_d=1, rd1_d=32'h11, rd2_d=32'h22, imm_ext_d=32'h33, alusrc_d=1, rd_d=5 → next edge srcb_e=32'h33, writedata_e=32'h22, rd_e=5, valid_e=1. With alusrc_d=0 → srcb_e=32'h22.
- Load-use: E holds a load (resultsrc_e=1, regwrite_e=1, rd_e=7); D has rs2_d=7 → stall_d=1. Next edge valid_e=0 and all controls 0. The following edge captures the D instruction. With rd_e=0 → stall_d=0 and no bubble.
- Hold: stall_e=1 for 3 cycles while D inputs change → _e outputs unchanged, stall_d=1. Release → the current D is captured.
- Flush priority: flush_e=1 and stall_e=1 on the same edge, with a valid instruction in E → valid_e=0, memwrite_e=0. With ID_EX_PERF_CNT_EN defined, flush_cnt increments by 1.
- Invalid slot: valid_d=0, memwrite_d=1, regwrite_d=1 → memwrite_e=0, regwrite_e=0, valid_e=0.
